// File: rtl/fp_adder_unit.sv
// Single-cycle registered floating-point adder with flush-to-zero inputs and overflow/underflow flags.
// Define FPA_ROUND_NEAREST_EN for round-to-nearest-even; otherwise results truncate toward zero.
module fp_adder_unit #(
    parameter int unsigned EXP_WIDTH      = 8,
    parameter int unsigned MANTISSA_WIDTH = 23
) (
    input  logic                                clock_in,
    input  logic                                reset_in,
    input  logic [EXP_WIDTH+MANTISSA_WIDTH:0]   a_in,
    input  logic [EXP_WIDTH+MANTISSA_WIDTH:0]   b_in,
    output logic [EXP_WIDTH+MANTISSA_WIDTH:0]   fpa_out,
    output logic                                overflow_out,
    output logic                                underflow_out
);

    localparam int E    = int'(EXP_WIDTH);
    localparam int M    = int'(MANTISSA_WIDTH);
    localparam int XW   = M + 4;
    localparam int EMAX = (1 << E) - 1;
    localparam logic [E-1:0]  EXP_ONES = '1;
    localparam logic [XW-1:0] ONES     = '1;
    localparam logic [E+M:0]  QNAN     = {1'b0, EXP_ONES, 1'b1, {(M-1){1'b0}}};

    logic         sa, sb;
    logic [E-1:0] ea, eb;
    logic [M-1:0] fa, fb;

    assign {sa, ea, fa} = a_in;
    assign {sb, eb, fb} = b_in;

    logic          swap, sl;
    logic [E-1:0]  el, es;
    logic [XW-1:0] ml, ms, aligned, dif, norm;
    logic [XW:0]   sum;
    logic [M-1:0]  frac;
    int            diff, lzc, exp_r;
    logic          nan_a, nan_b, inf_a, inf_b, za, zb;
    logic [E+M:0]  res;
    logic          ovf, unf;
`ifdef FPA_ROUND_NEAREST_EN
    logic [M+1:0]  mant;
`endif

    always_comb begin
        swap = {eb, fb} > {ea, fa};
        sl   = swap ? sb : sa;
        el   = swap ? eb : ea;
        es   = swap ? ea : eb;
        ml   = {1'b1, (swap ? fb : fa), 3'b000};
        ms   = {1'b1, (swap ? fa : fb), 3'b000};
        diff = int'(el) - int'(es);

        // Bits shifted past the round position collapse into the sticky LSB.
        if (diff >= XW - 1) begin
            aligned = {{(XW-1){1'b0}}, 1'b1};
        end else begin
            aligned    = ms >> diff;
            aligned[0] = aligned[0] | (|(ms & ~(ONES << diff)));
        end

        sum   = {1'b0, ml} + {1'b0, aligned};
        dif   = ml - aligned;
        lzc   = 0;
        exp_r = int'(el);
        if (sa == sb) begin
            if (sum[XW]) begin
                norm  = {sum[XW:2], sum[1] | sum[0]};
                exp_r = exp_r + 1;
            end else begin
                norm = sum[XW-1:0];
            end
        end else begin
            for (int i = 0; i < XW; i++) begin
                if (dif[i]) lzc = XW - 1 - i;
            end
            norm  = dif << lzc;
            exp_r = exp_r - lzc;
        end

`ifdef FPA_ROUND_NEAREST_EN
        mant = {1'b0, norm[XW-1:3]};
        if (norm[2] & (norm[1] | norm[0] | norm[3])) begin
            mant = mant + {{(M+1){1'b0}}, 1'b1};
        end
        frac  = mant[M+1] ? mant[M:1] : mant[M-1:0];
        exp_r = exp_r + int'(mant[M+1]);
`else
        frac = norm[XW-2:3];
`endif

        nan_a = (ea == EXP_ONES) && (fa != '0);
        nan_b = (eb == EXP_ONES) && (fb != '0);
        inf_a = (ea == EXP_ONES) && (fa == '0);
        inf_b = (eb == EXP_ONES) && (fb == '0);
        za    = (ea == '0);
        zb    = (eb == '0);

        res = '0;
        ovf = 1'b0;
        unf = 1'b0;
        if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) begin
            res = QNAN;
        end else if (inf_a) begin
            res = a_in;
        end else if (inf_b) begin
            res = b_in;
        end else if (za && zb) begin
            res = {sa & sb, {(E+M){1'b0}}};
        end else if (za) begin
            res = b_in;
        end else if (zb) begin
            res = a_in;
        end else if (norm == '0) begin
            res = '0;
        end else if (exp_r >= EMAX) begin
            res = {sl, EXP_ONES, {M{1'b0}}};
            ovf = 1'b1;
        end else if (exp_r <= 0) begin
            res = {sl, {(E+M){1'b0}}};
            unf = 1'b1;
        end else begin
            res = {sl, exp_r[E-1:0], frac};
        end
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            fpa_out       <= '0;
            overflow_out  <= 1'b0;
            underflow_out <= 1'b0;
        end else begin
            fpa_out       <= res;
            overflow_out  <= ovf;
            underflow_out <= unf;
        end
    end

endmodule

// File: tb/tb_fp_adder_unit.sv
// Scoreboard bench for fp_adder_unit: directed sums plus random operands checked against
// an exact-arithmetic reference model.
module tb_fp_adder_unit;

    logic        clock_in = 1'b0;
    logic        reset_in = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic [31:0] fpa_out;
    logic        overflow_out;
    logic        underflow_out;

    fp_adder_unit #(
        .EXP_WIDTH      (8),
        .MANTISSA_WIDTH (23)
    ) dut (
        .clock_in      (clock_in),
        .reset_in      (reset_in),
        .a_in          (a_in),
        .b_in          (b_in),
        .fpa_out       (fpa_out),
        .overflow_out  (overflow_out),
        .underflow_out (underflow_out)
    );

    always #5 clock_in = ~clock_in;

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
    } out_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        out_t        o;
    } entry_t;

    entry_t sb_q[$];
    entry_t cur;
    int     checks = 0;
    int     errors = 0;

    // Exact sum on a wide integer grid anchored at the larger exponent; a far-away smaller
    // operand is replaced by one grid unit, which lies strictly below every rounding position.
    function automatic out_t model(input logic [31:0] a, input logic [31:0] b);
        out_t        r;
        logic        a_big, sl;
        int          ea, eb, el, es, d, p, sh, e;
        logic [95:0] bg, sm, s, q, rem, half;
        r  = '0;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0) ||
            (ea == 255 && eb == 255 && a[31] != b[31])) begin
            r.res = 32'h7FC00000;
        end else if (ea == 255) begin
            r.res = a;
        end else if (eb == 255) begin
            r.res = b;
        end else if (ea == 0 && eb == 0) begin
            r.res = {a[31] & b[31], 31'd0};
        end else if (ea == 0) begin
            r.res = b;
        end else if (eb == 0) begin
            r.res = a;
        end else begin
            a_big = a[30:0] >= b[30:0];
            sl    = a_big ? a[31] : b[31];
            el    = a_big ? ea : eb;
            es    = a_big ? eb : ea;
            d     = el - es;
            bg    = {72'd0, 1'b1, (a_big ? a[22:0] : b[22:0])} << 40;
            sm    = {72'd0, 1'b1, (a_big ? b[22:0] : a[22:0])} << 40;
            sm    = (d > 40) ? 96'd1 : (sm >> d);
            s     = (a[31] == b[31]) ? bg + sm : bg - sm;
            if (s != 96'd0) begin
                p = 0;
                for (int i = 0; i < 96; i++) begin
                    if (s[i]) p = i;
                end
                sh   = p - 23;
                q    = s >> sh;
                rem  = s & ((96'd1 << sh) - 96'd1);
                half = 96'd1 << (sh - 1);
`ifdef FPA_ROUND_NEAREST_EN
                if (rem > half || (rem == half && q[0])) q = q + 96'd1;
                if (q[24]) begin
                    q = q >> 1;
                    p = p + 1;
                end
`else
                if (rem > half) q = q;
`endif
                e = el + p - 63;
                if (e >= 255) begin
                    r.res = {sl, 8'hFF, 23'd0};
                    r.ovf = 1'b1;
                end else if (e <= 0) begin
                    r.res = {sl, 31'd0};
                    r.unf = 1'b1;
                end else begin
                    r.res = {sl, e[7:0], q[22:0]};
                end
            end
        end
        return r;
    endfunction

    task automatic issue_exp(input logic [31:0] a, input logic [31:0] b, input out_t o);
        entry_t en;
        @(negedge clock_in);
        a_in = a;
        b_in = b;
        en.a = a;
        en.b = b;
        en.o = o;
        sb_q.push_back(en);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        issue_exp(a, b, model(a, b));
    endtask

    task automatic chk(input string name, input logic [33:0] got, input logic [33:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, want);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clock_in);
        checks++;
        if (sb_q.size() > 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", sb_q.size());
        end
    endtask

    always @(posedge clock_in) begin
        #1;
        if (!reset_in && sb_q.size() > 0) begin
            cur = sb_q.pop_front();
            checks++;
            if ({fpa_out, overflow_out, underflow_out} !== cur.o) begin
                errors++;
                $display("FAIL sum a=%h b=%h got %h ovf=%b unf=%b expected %h ovf=%b unf=%b",
                         cur.a, cur.b, fpa_out, overflow_out, underflow_out,
                         cur.o.res, cur.o.ovf, cur.o.unf);
            end
            checks++;
            if (overflow_out && underflow_out) begin
                errors++;
                $display("FAIL flags_exclusive got 11 expected not both set");
            end
        end
    end

    initial begin
        logic [31:0] a, b;
        int          mode;

        // Asynchronous reset seen before any clock edge, operands toggling.
        #1 reset_in = 1'b1;
        a_in = 32'h3F800000;
        b_in = 32'h3F800000;
        #1 chk("reset_async", {fpa_out, overflow_out, underflow_out}, 34'd0);
        a_in = 32'h7F7FFFFF;
        b_in = 32'h7F7FFFFF;
        #10 chk("reset_held", {fpa_out, overflow_out, underflow_out}, 34'd0);
        @(negedge clock_in);
        reset_in = 1'b0;

        issue_exp(32'h3F800000, 32'h3F800000, '{32'h40000000, 1'b0, 1'b0});
        issue_exp(32'h40000000, 32'h3F800000, '{32'h40400000, 1'b0, 1'b0});
        issue_exp(32'h40400000, 32'h40000000, '{32'h40A00000, 1'b0, 1'b0});
        issue_exp(32'h3FC00000, 32'h40200000, '{32'h40800000, 1'b0, 1'b0});
        issue_exp(32'h40400000, 32'hC0400000, '{32'h00000000, 1'b0, 1'b0});
        issue_exp(32'h40A00000, 32'hC0400000, '{32'h40000000, 1'b0, 1'b0});
        issue_exp(32'h7F7FFFFF, 32'h7F7FFFFF, '{32'h7F800000, 1'b1, 1'b0});
        issue_exp(32'hFF7FFFFF, 32'hFF7FFFFF, '{32'hFF800000, 1'b1, 1'b0});
        issue_exp(32'h00C00000, 32'h80800000, '{32'h00000000, 1'b0, 1'b1});
`ifdef FPA_ROUND_NEAREST_EN
        issue_exp(32'h3F800000, 32'h33C00000, '{32'h3F800001, 1'b0, 1'b0});
`else
        issue_exp(32'h3F800000, 32'h33C00000, '{32'h3F800000, 1'b0, 1'b0});
`endif
        issue_exp(32'h3F800000, 32'h33800000, '{32'h3F800000, 1'b0, 1'b0});
        issue_exp(32'h7F800000, 32'h3F800000, '{32'h7F800000, 1'b0, 1'b0});
        issue_exp(32'hFF800000, 32'hFF800000, '{32'hFF800000, 1'b0, 1'b0});
        issue_exp(32'h7F800000, 32'hFF800000, '{32'h7FC00000, 1'b0, 1'b0});
        issue_exp(32'h7F800123, 32'h3F800000, '{32'h7FC00000, 1'b0, 1'b0});
        issue_exp(32'h00000000, 32'hC0400000, '{32'hC0400000, 1'b0, 1'b0});
        issue_exp(32'hC0A00000, 32'h00000000, '{32'hC0A00000, 1'b0, 1'b0});
        drain();

        // Reset in the middle of an operation discards the in-flight result.
        @(negedge clock_in);
        a_in = 32'h3F800000;
        b_in = 32'h3F800000;
        @(posedge clock_in);
        #2 reset_in = 1'b1;
        #1 chk("reset_mid", {fpa_out, overflow_out, underflow_out}, 34'd0);
        @(negedge clock_in);
        reset_in = 1'b0;
        #1 chk("reset_release", {fpa_out, overflow_out, underflow_out}, 34'd0);
        issue_exp(32'h40400000, 32'h40000000, '{32'h40A00000, 1'b0, 1'b0});

        for (int i = 0; i < 400; i++) begin
            a    = $urandom;
            b    = $urandom;
            mode = $urandom_range(0, 9);
            case (mode)
                0: b[30:23] = a[30:23];
                1: b = {~a[31], a[30:0]};
                2: b = {~a[31], a[30:0] ^ 31'(1 << $urandom_range(0, 3))};
                3: b[30:23] = a[30:23] - 8'($urandom_range(0, 30));
                4: begin
                    a[30:23] = 8'hFE;
                    b[30:23] = 8'($urandom_range(248, 254));
                    b[31]    = a[31];
                end
                5: begin
                    a[30:23] = 8'($urandom_range(1, 2));
                    b[30:23] = 8'($urandom_range(1, 2));
                    b[31]    = ~a[31];
                end
                6: begin
                    a[30:23] = 8'hFF;
                    if ($urandom_range(0, 1) == 1) a[22:0] = '0;
                    if ($urandom_range(0, 1) == 1) b[30:0] = {8'hFF, 23'd0};
                end
                7: b[30:23] = 8'h00;
                default: ;
            endcase
            issue(a, b);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_adder_unit.md
Name: fp_adder_unit

Overview:
- Parameterised IEEE-754-style floating-point adder with sign, biased exponent and hidden-one mantissa fields.
- Adds two operands and registers the sum plus overflow/underflow flags on one clock.
- Sits in the datapath as a pipelined arithmetic unit and is driven and observed through fpa_interface.

Parameters:
- EXP_WIDTH, 8, exponent field width; bias = 2^(EXP_WIDTH-1)-1.
- MANTISSA_WIDTH, 23, stored fraction width (hidden bit excluded).

Ports:
- clock_in  input  1  clock; all state on rising edge.
- reset_in  input  1  asynchronous, active-high reset.
- a_in  input  1+EXP_WIDTH+MANTISSA_WIDTH  operand A {sign, exponent, fraction}.
- b_in  input  1+EXP_WIDTH+MANTISSA_WIDTH  operand B, same format.
- fpa_out  output  1+EXP_WIDTH+MANTISSA_WIDTH  registered sum A+B.
- overflow_out  output  1  registered; result exponent exceeded maximum finite.
- underflow_out  output  1  registered; nonzero result too small for a normal number.

Behaviour:
- Reset: while reset_in=1, fpa_out=0, overflow_out=0, underflow_out=0, independent of the clock.
- Latency: 1 cycle. Operands sampled at the rising edge. Result and flags valid after that edge. A new operand pair is accepted every cycle; there is no handshake.
- Combinational datapath:
  - Unpack both operands. Exponent=0 inputs are zero (denormals flushed to signed zero). Otherwise prepend the hidden 1.
  - Order by magnitude (exponent, then mantissa). Align the smaller operand by right-shifting it by the exponent difference. Keep guard, round and sticky bits; if the shift is ≥ MANTISSA_WIDTH+3, the smaller operand becomes sticky only.
  - Equal signs: add mantissas. On carry out, shift right 1 and increment the exponent.
  - Differing signs: subtract smaller from larger. Normalise with a leading-zero count left shift and decrease the exponent by the count.
  - Round (see Optional Feature). A rounding carry renormalises and increments the exponent.
  - Result sign is the sign of the larger-magnitude operand.
  - Exact cancellation gives +0, flags 0.
  - One zero operand: result equals the other operand bit-exactly.
- Overflow: final biased exponent ≥ 2^EXP_WIDTH-1 → fpa_out = signed infinity (exponent all ones, fraction 0), overflow_out=1.
- Underflow: nonzero result with final biased exponent ≤ 0 → fpa_out = signed zero, underflow_out=1.
- Special inputs (exponent all ones):
  - Infinity plus a finite value gives that infinity, flags 0.
  - Infinity plus infinity of the same sign gives that infinity.
  - Opposite-sign infinities, or any NaN input, give quiet NaN: sign 0, exponent all ones, fraction MSB 1, remaining fraction bits 0. Flags 0.
- overflow_out and underflow_out are never both 1.
- Reset asserted mid-operation discards the in-flight result. The first valid output after deassertion comes one edge after the first sampled operands.

Optional Feature:
- Macro FPA_ROUND_NEAREST_EN.
- Defined: round to nearest, ties to even, using guard/round/sticky.
- Undefined: truncate toward zero and discard guard/round/sticky. No rounding carry path, so overflow can only arise from the add/carry step.

Test Plan:
- Reset: assert reset_in with operands toggling → fpa_out=00000000, both flags 0, immediately and with no clock edge needed.
- Basic and Fibonacci sums (default params): 3F800000+3F800000 → 40000000. Then 40000000+3F800000 → 40400000. Then 40400000+40000000 → 40A00000. Each appears one edge after its operands are applied. Then 3FC00000+40200000 → 40800000.
- Cancellation and mixed signs: 40400000+C0400000 → 00000000 with flags 0. 40A00000+C0400000 → 40000000.
- Overflow: 7F7FFFFF+7F7FFFFF → 7F800000 with overflow_out=1. FF7FFFFF+FF7FFFFF → FF800000 with overflow_out=1.
- Underflow: 00C00000+80800000 → 00000000 with underflow_out=1 and overflow_out=0.
- Rounding: 3F800000+33C00000 → 3F800001 with FPA_ROUND_NEAREST_EN defined, 3F800000 without it. 3F800000+33800000 (tie) → 3F800000 in both builds.
